// File: rtl/xdma_h2c_pkt_fifo.sv
// Store-and-forward AXI-Stream packet buffer on the XDMA H2C path; packets longer than the buffer are dropped whole.
// Optional statistics counters (stat_pkt_in / stat_pkt_drop) are built when XDMA_PKT_FIFO_STATS_EN is defined.
module xdma_h2c_pkt_fifo #(
    parameter int TDATA_WIDTH = 512,
    parameter int TKEEP_WIDTH = 64,
    parameter int TUSER_WIDTH = 1,
    parameter int DEPTH_LOG   = 6
) (
    input  logic                   xdma_axi_aclk,
    input  logic                   xdma_axi_aresetn,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic [TKEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [TUSER_WIDTH-1:0] s_axis_tuser,
    input  logic                   s_axis_tlast,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [TDATA_WIDTH-1:0] m_axis_tdata,
    output logic [TKEEP_WIDTH-1:0] m_axis_tkeep,
    output logic [TUSER_WIDTH-1:0] m_axis_tuser,
    output logic                   m_axis_tlast,
    output logic [DEPTH_LOG:0]     pkt_count,
    output logic                   drop_pulse
`ifdef XDMA_PKT_FIFO_STATS_EN
    ,
    output logic [31:0]            stat_pkt_in,
    output logic [31:0]            stat_pkt_drop
`endif
);

    localparam int DEPTH  = 2**DEPTH_LOG;
    localparam int PW     = DEPTH_LOG + 1;
    localparam int BEAT_W = TDATA_WIDTH + TKEEP_WIDTH + TUSER_WIDTH + 1;
    localparam logic [PW-1:0] ONE      = PW'(1);
    localparam logic [PW-1:0] DEPTH_P  = PW'(DEPTH);
    localparam logic [PW-1:0] LAST_CNT = PW'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, FILL, DROP} state_t;

    state_t              state;
    logic [PW-1:0]       wr_ptr, commit_ptr, rd_ptr, fetch_ptr, beat_cnt, used;
    logic                full, rdy_en, s_hs, wr_en, commit, m_hs, out_last_hs, fetch;
    logic                skid_v;
    logic [BEAT_W-1:0]   mem [DEPTH];
    logic [BEAT_W-1:0]   out_q, skid_q, rd_beat;

    assign used          = wr_ptr - rd_ptr;
    assign full          = (used == DEPTH_P);
    assign s_axis_tready = rdy_en && (!full || state == DROP);
    assign s_hs          = s_axis_tvalid && s_axis_tready;
    assign wr_en         = s_hs && (state != DROP);
    assign commit        = wr_en && s_axis_tlast;

    assign m_hs          = m_axis_tvalid && m_axis_tready;
    assign out_last_hs   = m_hs && m_axis_tlast;
    // Only committed beats are fetched, so a partial packet never reaches the output.
    assign fetch         = (fetch_ptr != commit_ptr) && (!m_axis_tvalid || !skid_v || m_hs);
    assign rd_beat       = mem[fetch_ptr[DEPTH_LOG-1:0]];

    assign m_axis_tdata  = out_q[TDATA_WIDTH-1:0];
    assign m_axis_tkeep  = out_q[TDATA_WIDTH +: TKEEP_WIDTH];
    assign m_axis_tlast  = out_q[TDATA_WIDTH + TKEEP_WIDTH];
    assign m_axis_tuser  = out_q[BEAT_W-1 -: TUSER_WIDTH];

    always_ff @(posedge xdma_axi_aclk) begin
        if (wr_en)
            mem[wr_ptr[DEPTH_LOG-1:0]] <= {s_axis_tuser, s_axis_tlast, s_axis_tkeep, s_axis_tdata};
    end

    // Input FSM: beat_cnt holds beats already accepted for the current packet.
    always_ff @(posedge xdma_axi_aclk or negedge xdma_axi_aresetn) begin
        if (!xdma_axi_aresetn) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            beat_cnt   <= '0;
            rdy_en     <= 1'b0;
            drop_pulse <= 1'b0;
        end else begin
            rdy_en     <= 1'b1;
            drop_pulse <= 1'b0;
            if (s_hs) begin
                case (state)
                    IDLE, FILL: begin
                        wr_ptr <= wr_ptr + ONE;
                        if (s_axis_tlast) begin
                            commit_ptr <= wr_ptr + ONE;
                            beat_cnt   <= '0;
                            state      <= IDLE;
                        end else if (beat_cnt == LAST_CNT) begin
                            // Buffer-sized packet still open: it can never fit, so rewind and discard.
                            wr_ptr   <= commit_ptr;
                            beat_cnt <= '0;
                            state    <= DROP;
                        end else begin
                            beat_cnt <= beat_cnt + ONE;
                            state    <= FILL;
                        end
                    end
                    default: begin
                        if (s_axis_tlast) begin
                            drop_pulse <= 1'b1;
                            state      <= IDLE;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge xdma_axi_aclk or negedge xdma_axi_aresetn) begin
        if (!xdma_axi_aresetn) begin
            pkt_count <= '0;
        end else begin
            case ({commit, out_last_hs})
                2'b10:   pkt_count <= pkt_count + ONE;
                2'b01:   pkt_count <= pkt_count - ONE;
                default: pkt_count <= pkt_count;
            endcase
        end
    end

    // Output stage: RAM read lands in the output register, or in the skid when the output is stalled.
    // rd_ptr frees RAM space only on the downstream handshake, so prefetched beats still count as used.
    always_ff @(posedge xdma_axi_aclk or negedge xdma_axi_aresetn) begin
        if (!xdma_axi_aresetn) begin
            rd_ptr        <= '0;
            fetch_ptr     <= '0;
            m_axis_tvalid <= 1'b0;
            skid_v        <= 1'b0;
            out_q         <= '0;
            skid_q        <= '0;
        end else begin
            if (m_hs)
                rd_ptr <= rd_ptr + ONE;
            if (fetch)
                fetch_ptr <= fetch_ptr + ONE;
            if (!m_axis_tvalid || m_hs) begin
                if (skid_v) begin
                    out_q         <= skid_q;
                    m_axis_tvalid <= 1'b1;
                    skid_v        <= fetch;
                    if (fetch)
                        skid_q <= rd_beat;
                end else begin
                    m_axis_tvalid <= fetch;
                    if (fetch)
                        out_q <= rd_beat;
                end
            end else if (fetch) begin
                skid_v <= 1'b1;
                skid_q <= rd_beat;
            end
        end
    end

`ifdef XDMA_PKT_FIFO_STATS_EN
    always_ff @(posedge xdma_axi_aclk or negedge xdma_axi_aresetn) begin
        if (!xdma_axi_aresetn) begin
            stat_pkt_in   <= '0;
            stat_pkt_drop <= '0;
        end else begin
            if (commit)
                stat_pkt_in <= stat_pkt_in + 32'd1;
            if (s_hs && state == DROP && s_axis_tlast)
                stat_pkt_drop <= stat_pkt_drop + 32'd1;
        end
    end
`endif

endmodule
